// File: rtl/imem_loader_if.sv
// Byte-stream loader bus: host-side byte handshake and control on one side,
// instruction-memory write port and status on the other.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0]   word_count;
  logic                  byte_valid;
  logic [7:0]            byte_in;
  logic                  byte_ready;
  logic                  wr_en;
  logic [31:0]           wr_addr;
  logic [31:0]           wr_data;
  logic                  busy;
  logic                  done;
  logic [31:0]           checksum;

  // Host / boot source side: issues the load and the byte stream
  modport master (
    output start, start_addr, word_count, byte_valid, byte_in,
    input  byte_ready, wr_en, wr_addr, wr_data, busy, done, checksum
  );

  // Loader side: consumes bytes and drives the memory write port
  modport slave (
    input  start, start_addr, word_count, byte_valid, byte_in,
    output byte_ready, wr_en, wr_addr, wr_data, busy, done, checksum
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a little-endian byte stream into 32-bit
// words and writes them to consecutive word addresses, keeping a running
// mod-2^32 checksum of the words written in the current load.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input logic         clk,
  input logic         reset,
  imem_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   wordsLeft_q;
  logic [1:0]            byteIdx_q;
  logic [23:0]           word_q;
  logic [ADDR_WIDTH-1:0] wrAddr_q;
  logic [31:0]           wrData_q;
  logic [31:0]           checksum_q;
  logic                  byteReady_q;
  logic                  wrEn_q;
  logic                  busy_q;
  logic                  done_q;

  logic [ADDR_WIDTH-1:0] addr_d;
  logic [ADDR_WIDTH:0]   wordsLeft_d;
  logic [31:0]           checksum_d;

  // Arithmetic applied when a word leaves WRITE: next address (wraps), remaining count, checksum
  always_comb begin
    addr_d      = addr_q + 1'b1;
    wordsLeft_d = wordsLeft_q - 1'b1;
    checksum_d  = checksum_q + wrData_q;
  end

  // Load sequencer: collects four bytes per word, issues one write strobe, then pulses done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wordsLeft_q <= '0;
      byteIdx_q   <= '0;
      word_q      <= '0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      checksum_q  <= '0;
      byteReady_q <= 1'b0;
      wrEn_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            addr_q      <= bus.start_addr;
            wordsLeft_q <= bus.word_count;
            checksum_q  <= '0;
            byteIdx_q   <= '0;
            busy_q      <= 1'b1;
            if (bus.word_count == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= COLLECT;
              byteReady_q <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (bus.byte_valid && byteReady_q) begin
            byteIdx_q <= byteIdx_q + 1'b1;
            case (byteIdx_q)
              2'd0: word_q[7:0]   <= bus.byte_in;
              2'd1: word_q[15:8]  <= bus.byte_in;
              2'd2: word_q[23:16] <= bus.byte_in;
              default: begin
                wrData_q    <= {bus.byte_in, word_q};
                wrAddr_q    <= addr_q;
                wrEn_q      <= 1'b1;
                byteReady_q <= 1'b0;
                state_q     <= WRITE;
              end
            endcase
          end
        end
        WRITE: begin
          wrEn_q      <= 1'b0;
          checksum_q  <= checksum_d;
          addr_q      <= addr_d;
          wordsLeft_q <= wordsLeft_d;
          byteIdx_q   <= '0;
          if (wordsLeft_q == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q     <= COLLECT;
            byteReady_q <= 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.byte_ready = byteReady_q;
  assign bus.wr_en      = wrEn_q;
  assign bus.wr_addr    = {{(32-ADDR_WIDTH){1'b0}}, wrAddr_q};
  assign bus.wr_data    = wrData_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.checksum   = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a stimulus process queues the writes and checksum
// each load should produce; a negedge monitor pops and compares them as the
// loader presents wr_en / done, and mirrors writes into a memory array.
module tb_imem_loader;

  localparam int AW        = 8;
  localparam int MEM_WORDS = 1 << AW;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rstN;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (rstN),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  wr_t         expWrQ[$];
  logic [31:0] expSumQ[$];
  logic [31:0] stimWords[$];
  logic [31:0] tbMem [MEM_WORDS];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int startCyc = 0;
  int firstWrCyc = 0;
  int doneCyc = 0;
  int wrCount = 0;
  bit trackFirst = 1'b0;
  bit prevWrEn = 1'b0;
  bit prevDone = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s", name);
  endtask

  // Cycle counter used to measure latency from start to write and done
  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: compares every write strobe and done pulse against the scoreboard
  always @(negedge clk) begin
    if (rstN) begin
      if (bus.wr_en) begin
        wr_t e;
        wrCount++;
        if (trackFirst) begin
          firstWrCyc = cycle;
          trackFirst = 1'b0;
        end
        checkOutput("wr_en single cycle", {31'd0, prevWrEn}, 32'd0);
        checkOutput("byte_ready low in WRITE", {31'd0, bus.byte_ready}, 32'd0);
        if (expWrQ.size() == 0) begin
          failNow("unexpected wr_en with empty scoreboard");
        end else begin
          e = expWrQ.pop_front();
          checkOutput("wr_addr", bus.wr_addr, e.addr);
          checkOutput("wr_data", bus.wr_data, e.data);
        end
        tbMem[bus.wr_addr[AW-1:0]] = bus.wr_data;
      end
      if (bus.done) begin
        doneCyc = cycle;
        checkOutput("busy during done", {31'd0, bus.busy}, 32'd1);
        if (expSumQ.size() == 0) begin
          failNow("unexpected done with empty scoreboard");
        end else begin
          checkOutput("checksum at done", bus.checksum, expSumQ.pop_front());
        end
      end
      if (prevDone && !bus.done) begin
        checkOutput("busy dropped after done", {31'd0, bus.busy}, 32'd0);
      end
      prevWrEn = bus.wr_en;
      prevDone = bus.done;
    end else begin
      prevWrEn = 1'b0;
      prevDone = 1'b0;
    end
  end

  // Issues start on one edge; returns at the negedge right after it was sampled
  task automatic startLoad(input int addr, input int count);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.start_addr = addr[AW-1:0];
    bus.word_count = count[AW:0];
    trackFirst     = 1'b1;
    @(negedge clk);
    startCyc       = cycle;
    bus.start      = 1'b0;
    bus.start_addr = 8'($urandom);
    bus.word_count = 9'($urandom);
    checkOutput("busy after start", {31'd0, bus.busy}, 32'd1);
    checkOutput("byte_ready after start", {31'd0, bus.byte_ready},
                (count != 0) ? 32'd1 : 32'd0);
  endtask

  // Runs one complete load of stimWords; gapMode 0=every cycle, 1=every other, 2=random
  task automatic applyStimulus(input int addr, input int count, input int gapMode,
                               input bit glitch);
    logic [31:0] sum;
    logic [31:0] w;
    logic [7:0]  bytes[$];
    int          idx;
    int          guard;
    int          wrBefore;
    bit          v;
    bit          acc;
    bit          glitched;
    bit          sawDone;
    sum = 32'd0;
    for (int i = 0; i < count; i++) begin
      w = stimWords[i];
      expWrQ.push_back('{32'((addr + i) % MEM_WORDS), w});
      sum = sum + w;
      for (int b = 0; b < 4; b++) bytes.push_back(w[8*b +: 8]);
    end
    expSumQ.push_back(sum);
    wrBefore = wrCount;
    startLoad(addr, count);

    idx = 0;
    guard = 0;
    glitched = 1'b0;
    while (idx < bytes.size() && guard < 20000) begin
      if (gapMode == 0)      v = 1'b1;
      else if (gapMode == 1) v = (guard % 2) == 1;
      else                   v = $urandom_range(0, 2) != 0;
      bus.byte_valid = v;
      bus.byte_in    = v ? bytes[idx] : 8'($urandom);
      acc = v && bus.byte_ready;
      if (glitch && !glitched && idx == 2 && bus.byte_ready) begin
        bus.start      = 1'b1;
        bus.start_addr = 8'hC0;
        bus.word_count = 9'd5;
        glitched       = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (acc) idx++;
      guard++;
    end
    bus.byte_valid = 1'b0;
    bus.start      = 1'b0;
    if (idx < bytes.size()) failNow("timeout feeding bytes");

    guard = 0;
    sawDone = 1'b0;
    while (!sawDone && guard < 50) begin
      if (bus.done) begin
        sawDone = 1'b1;
        if (glitch) begin
          bus.start      = 1'b1;
          bus.start_addr = 8'hC4;
          bus.word_count = 9'd3;
        end
      end
      @(negedge clk);
      bus.start = 1'b0;
      guard++;
    end
    if (!sawDone) failNow("timeout waiting for done");

    if (gapMode == 0 && sawDone) begin
      if (count > 0) checkOutput("first write latency", 32'(firstWrCyc - startCyc), 32'd4);
      checkOutput("done latency", 32'(doneCyc - startCyc), 32'(5 * count));
    end
    repeat (3) @(negedge clk);
    checkOutput("write count of load", 32'(wrCount - wrBefore), 32'(count));
    checkOutput("idle after load", {31'd0, bus.busy}, 32'd0);
  endtask

  // Watchdog so a stuck design still ends the run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int addr;
    int count;
    int wrBefore;
    rstN           = 1'b0;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.word_count = '0;
    bus.byte_valid = 1'b0;
    bus.byte_in    = '0;
    #1;
    checkOutput("reset byte_ready", {31'd0, bus.byte_ready}, 32'd0);
    checkOutput("reset wr_en", {31'd0, bus.wr_en}, 32'd0);
    checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset done", {31'd0, bus.done}, 32'd0);
    checkOutput("reset wr_addr", bus.wr_addr, 32'd0);
    checkOutput("reset wr_data", bus.wr_data, 32'd0);
    checkOutput("reset checksum", bus.checksum, 32'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    // Single word, back-to-back bytes
    stimWords = '{32'h12345678};
    applyStimulus(32'h10, 1, 0, 1'b0);
    checkOutput("single word checksum held", bus.checksum, 32'h12345678);

    // Two words with byte_valid low every other cycle
    stimWords = '{32'h04030201, 32'h08070605};
    applyStimulus(32'h40, 2, 1, 1'b0);
    checkOutput("backpressure checksum held", bus.checksum, 32'h0C0A0806);

    // Address wrap across the top of memory
    stimWords = '{$urandom, $urandom, $urandom};
    applyStimulus(32'hFE, 3, 0, 1'b0);

    // Zero-length load
    stimWords = '{};
    applyStimulus(32'h33, 0, 0, 1'b0);
    checkOutput("zero load checksum", bus.checksum, 32'd0);

    // Reset mid-COLLECT after two bytes: nothing written, everything cleared
    wrBefore = wrCount;
    startLoad(32'h20, 1);
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'hEF;
    @(negedge clk);
    bus.byte_in    = 8'hBE;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    #1 rstN = 1'b0;
    #1;
    checkOutput("abort byte_ready", {31'd0, bus.byte_ready}, 32'd0);
    checkOutput("abort busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("abort wr_en", {31'd0, bus.wr_en}, 32'd0);
    checkOutput("abort wr_addr", bus.wr_addr, 32'd0);
    checkOutput("abort wr_data", bus.wr_data, 32'd0);
    checkOutput("abort checksum", bus.checksum, 32'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    bus.byte_valid = 1'b1;
    repeat (10) @(negedge clk);
    bus.byte_valid = 1'b0;
    checkOutput("no write after abort", 32'(wrCount - wrBefore), 32'd0);

    // Start pulsed during COLLECT and during DONE is ignored
    stimWords = '{$urandom, $urandom};
    applyStimulus(32'h50, 2, 2, 1'b1);

    // Randomized loads
    for (int t = 0; t < 6; t++) begin
      addr  = $urandom_range(0, MEM_WORDS - 1);
      count = $urandom_range(1, 6);
      stimWords = '{};
      for (int i = 0; i < count; i++) stimWords.push_back($urandom);
      applyStimulus(addr, count, 2, 1'b0);
    end

    // Full 256-word image, then verify the mirrored memory
    stimWords = '{};
    for (int i = 0; i < MEM_WORDS; i++) stimWords.push_back(32'hA5000000 + 32'(i));
    applyStimulus(0, MEM_WORDS, 0, 1'b0);
    for (int i = 0; i < MEM_WORDS; i++) begin
      checkOutput($sformatf("image word %0d", i), tbMem[i], 32'hA5000000 + 32'(i));
    end

    checkOutput("pending writes", 32'(expWrQ.size()), 32'd0);
    checkOutput("pending done", 32'(expSumQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory loader: the write-side counterpart of `instrMem`, which only serves reads on `addr`/`data_out`. It accepts a byte stream over a valid/ready handshake, packs each group of four bytes little-endian into a 32-bit instruction word, and writes the words to consecutive word addresses of instruction memory. It sits between the host/boot byte source and the memory's write port, and reports a running checksum so the bench or host can confirm the image.

## Interface
- `ADDR_WIDTH`, default 8: word-address bits; 256-word memory. The address wraps modulo 2^ADDR_WIDTH.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: asynchronous, active-low. 0 = reset asserted.
- `start`  input  1: begin a load. Sampled only in IDLE.
- `start_addr`  input  ADDR_WIDTH: first word address of the load.
- `word_count`  input  ADDR_WIDTH+1: number of words to load, 0..2^ADDR_WIDTH.
- `byte_valid`  input  1: `byte_in` holds a byte.
- `byte_in`  input  8: stream byte.
- `byte_ready`  output  1: loader accepts a byte this cycle.
- `wr_en`  output  1: one-cycle write strobe to instruction memory.
- `wr_addr`  output  32: word address. Bits [31:ADDR_WIDTH] are always 0.
- `wr_data`  output  32: instruction word.
- `busy`  output  1: high in every state except IDLE.
- `done`  output  1: one-cycle completion pulse.
- `checksum`  output  32: mod-2^32 sum of the words written in the current or most recent load.

## Operation
- States: IDLE, COLLECT, WRITE, DONE. All outputs are registered.
- **IDLE**
  - `byte_ready`=0, `wr_en`=0, `busy`=0.
  - On `start`=1, latch `start_addr` into the address register, latch `word_count` into `words_left`, clear `checksum` and the byte index.
  - If `word_count`=0, go to DONE; otherwise go to COLLECT.
- **COLLECT**
  - `byte_ready`=1.
  - Each cycle with `byte_valid` && `byte_ready`, store `byte_in` into lane `byte_idx` (lane 0 → [7:0], lane 3 → [31:24]) and increment `byte_idx`.
  - When the 4th byte is accepted, go to WRITE.
  - `byte_valid`=0 cycles are idle cycles with no timeout.
- **WRITE**
  - `wr_en`=1 for exactly one cycle. `wr_addr` = address register, `wr_data` = assembled word.
  - `checksum` += word (carry out discarded).
  - Address register increments modulo 2^ADDR_WIDTH; `words_left` decrements; `byte_idx` resets to 0.
  - If `words_left` was 1, go to DONE; otherwise go to COLLECT.
- **DONE**
  - `done`=1 for one cycle, `busy`=1, then go to IDLE.
  - `checksum` holds its value until the next accepted `start`.
- `start` outside IDLE is ignored.
- `wr_addr`/`wr_data` hold their last values when `wr_en`=0.

## Timing
- Reset (`reset`=0, asynchronous): state = IDLE; `byte_ready`, `wr_en`, `busy`, `done` = 0; `wr_addr`, `wr_data`, `checksum` = 0; byte index and counters = 0.
- Reset asserted mid-load aborts the load. A partially assembled word is discarded and never written. Writes completed before reset stay in memory.
- Timing from `start` sampled at edge N:
  - `busy`=1 and `byte_ready`=1 from N+1.
  - With bytes valid every cycle, bytes are accepted at N+1..N+4 and `wr_en`=1 during N+5.
  - `byte_ready`=0 during WRITE.
  - The next word's bytes are accepted from N+6.
- Peak throughput: 5 cycles per word.
- Completion: `done` is asserted in the cycle after the last `wr_en`, and `busy` drops one cycle later. With `word_count`=0, `done`=1 at N+1 and no `wr_en` is issued.
- Address wrap: `start_addr`=2^ADDR_WIDTH−1 followed by another word writes that address, then 0.

## Test plan
- **Reset:** drive `reset`=0 at any time, including mid-COLLECT with 2 bytes taken → all outputs 0 immediately, no `wr_en`. After `reset`=1, a new `start` is accepted normally.
- **Single word:** `start_addr`=0x10, `word_count`=1, bytes 0x78,0x56,0x34,0x12 on consecutive cycles → one `wr_en` with `wr_addr`=0x10, `wr_data`=0x12345678, exactly 5 cycles after `start`. Then `done` pulse, `checksum`=0x12345678.
- **Backpressure gaps:** `word_count`=2, bytes 0x01..0x08 with `byte_valid` low every other cycle → writes 0x04030201 @ `start_addr` and 0x08070605 @ `start_addr`+1. `checksum`=0x0C0A0806.
- **Wrap and zero count:** `start_addr`=0xFE, `word_count`=3 → `wr_addr` sequence 0xFE, 0xFF, 0x00. Separately, `word_count`=0 → `done` one cycle after `start`, no `wr_en`.
- **Full image:** `word_count`=256, `start_addr`=0 with word i = 0xA5000000+i, then read `instrMem` at addr 0..255 → every `data_out` matches and `checksum` equals the sum of all 256 words mod 2^32.
- **Start while busy:** pulse `start` during COLLECT and during DONE → ignored; the current load completes unchanged.
